// File: rtl/game_pkg.sv
// Shared screen geometry, dispatcher state encoding and slot-priority helper
// for the bullet subsystem.
package game_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int BULLET_W = 4;

  typedef enum logic {
    READY    = 1'b0,
    COOLDOWN = 1'b1
  } dispatch_state_t;

  // Index of the lowest clear bit; callers pad unused slots with ones and
  // check for "no free slot" separately.
  function automatic logic [2:0] lowest_free_idx(input logic [7:0] busy);
    logic [2:0] idx;
    logic       hit;
    idx = 3'd0;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!busy[i] && !hit) begin
        idx = 3'(i);
        hit = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/vs_edge_sync.sv
// Brings the asynchronous VGA vertical sync into the clock domain and emits
// a single-cycle pulse on each rising edge, three clocks after the VS rise.
module vs_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic vs,
  output logic tick
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
      tick    <= 1'b0;
    end else begin
      sync_p0 <= vs;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
      // Registered so the pulse leaves the block glitch-free.
      tick    <= sync_p1 & ~prev_p2;
    end
  end

endmodule

// File: rtl/bullet_dispatcher.sv
// Turns the fire key into per-frame, cooldown-limited one-hot launch pulses,
// tracks in-flight bullet slots and computes the clamped muzzle position.
module bullet_dispatcher #(
  parameter int NUM_BULLETS     = 6,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int BULLET_W        = game_pkg::BULLET_W,
  parameter int SCREEN_W        = game_pkg::SCREEN_W,
  parameter int SCREEN_H        = game_pkg::SCREEN_H
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   VS,
  input  logic                   fire_key,
  input  logic                   shootingEnable,
  input  logic                   direction,
  input  logic [9:0]             PlayerX,
  input  logic [9:0]             PlayerY,
  input  logic [9:0]             PlayerWidth,
  input  logic [9:0]             PlayerHeight,
  input  logic [NUM_BULLETS-1:0] bullet_done,
  output logic [NUM_BULLETS-1:0] fire,
  output logic [9:0]             spawnX,
  output logic [9:0]             spawnY,
  output logic                   spawnDir,
  output logic [NUM_BULLETS-1:0] slot_busy,
  output logic                   frame_tick
);

  import game_pkg::*;

  localparam logic [10:0] X_MAX    = 11'(SCREEN_W - 1);
  localparam logic [10:0] Y_MAX    = 11'(SCREEN_H - 1);
  localparam logic [10:0] X_OFFSET = 11'(BULLET_W);
  localparam logic [7:0]  CD_LOAD  = 8'(COOLDOWN_FRAMES - 1);

  function automatic logic [9:0] sat_upper(input logic [10:0] v,
                                           input logic [10:0] lim);
    logic [10:0] r;
    r = (v > lim) ? lim : v;
    return r[9:0];
  endfunction

  function automatic logic [9:0] sat_sub_zero(input logic [10:0] a,
                                              input logic [10:0] b);
    logic [10:0] d;
    d = (a < b) ? 11'd0 : (a - b);
    return d[9:0];
  endfunction

  dispatch_state_t state;
  dispatch_state_t state_next;
  logic [7:0]      cd_cnt;
  logic            key_hist;

  logic            press_p0;
  logic            launch_p0;
  logic            has_free_p0;
  logic [7:0]      busy_pad_p0;
  logic [2:0]      free_idx_p0;
  logic [NUM_BULLETS-1:0] free_p0;
  logic [9:0]      spawn_x_p0;
  logic [9:0]      spawn_y_p0;

  vs_edge_sync u_vs_edge_sync (
    .clk  (Clk),
    .rst  (Reset),
    .vs   (VS),
    .tick (frame_tick)
  );

  // Stage p0: frame-qualified key edge, slot pick and spawn arithmetic
  assign press_p0 = frame_tick & fire_key & ~key_hist;

  always_comb begin
    busy_pad_p0 = '1;
    busy_pad_p0[NUM_BULLETS-1:0] = slot_busy;
  end

  assign free_idx_p0 = lowest_free_idx(busy_pad_p0);
  assign has_free_p0 = ~&busy_pad_p0;

  always_comb begin
    free_p0 = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      free_p0[i] = (free_idx_p0 == 3'(i));
    end
  end

  always_comb begin
    spawn_x_p0 = sat_sub_zero({1'b0, PlayerX}, X_OFFSET);
    if (direction) begin
      spawn_x_p0 = sat_upper({1'b0, PlayerX} + {1'b0, PlayerWidth}, X_MAX);
    end
    spawn_y_p0 = sat_upper({1'b0, PlayerY} + (11'(PlayerHeight) >> 2), Y_MAX);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      key_hist <= 1'b0;
    end else if (frame_tick) begin
      key_hist <= fire_key;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= READY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      READY: begin
        if (launch_p0) begin
          state_next = COOLDOWN;
        end
      end
      COOLDOWN: begin
        // Leaving on the tick that exhausts the count lets the very next
        // frame launch, giving COOLDOWN_FRAMES frames between launches.
        if (frame_tick && (cd_cnt <= 8'd1)) begin
          state_next = READY;
        end
      end
      default: state_next = READY;
    endcase
  end

  always_comb begin
    launch_p0 = 1'b0;
    if (state == READY) begin
      launch_p0 = press_p0 & shootingEnable & has_free_p0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cd_cnt <= 8'd0;
    end else if (launch_p0) begin
      cd_cnt <= CD_LOAD;
    end else if ((state == COOLDOWN) && frame_tick && (cd_cnt != 8'd0)) begin
      cd_cnt <= cd_cnt - 8'd1;
    end
  end

  // Stage p1: launch pulse, slot occupancy and held spawn bus
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fire      <= '0;
      slot_busy <= '0;
      spawnX    <= 10'd0;
      spawnY    <= 10'd0;
      spawnDir  <= 1'b0;
    end else begin
      fire      <= launch_p0 ? free_p0 : '0;
      slot_busy <= (slot_busy & ~bullet_done) | (launch_p0 ? free_p0 : '0);
      if (launch_p0) begin
        spawnX   <= spawn_x_p0;
        spawnY   <= spawn_y_p0;
        spawnDir <= direction;
      end
    end
  end

endmodule

// File: doc/bullet_dispatcher.md
Name: bullet_dispatcher

Overview:
Upstream stage of the bullet slot array. Turns the player's fire input into single-cycle per-slot launch pulses, once per frame. Tracks which of NUM_BULLETS slots are in flight and enforces a frame-based cooldown. Computes the muzzle spawn coordinates from player position and facing. Each slot consumes one fire bit plus the shared spawn bus, and reports completion back through bullet_done when it leaves the screen or collides.

Parameters:
NUM_BULLETS, 6, number of bullet slots managed (1..8)
COOLDOWN_FRAMES, 8, minimum frames between two launches (1..255)
BULLET_W, 4, bullet sprite width in pixels, used for left-facing spawn
SCREEN_W, 640, horizontal clamp limit
SCREEN_H, 480, vertical clamp limit

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
VS  in  1  vertical sync from VGA controller, asynchronous to logic, frame marker
fire_key  in  1  fire button level decoded from keycode
shootingEnable  in  1  global permission to shoot (0 during death/respawn)
direction  in  1  player facing, 1 = right, 0 = left
PlayerX, PlayerY, PlayerWidth, PlayerHeight  in  10 each  player bounding box
bullet_done  in  NUM_BULLETS  per-slot single-cycle pulse: slot has finished
fire  out  NUM_BULLETS  one-hot, single-cycle launch pulse
spawnX, spawnY  out  10 each  launch position, valid in the cycle fire is nonzero
spawnDir  out  1  launch direction, valid with fire
slot_busy  out  NUM_BULLETS  slot currently in flight
frame_tick  out  1  single-cycle pulse on each synchronised VS rising edge

Behaviour:
- Reset is asynchronous and active-high. While asserted: fire=0, spawnX=0, spawnY=0, spawnDir=0, slot_busy=0, frame_tick=0, cooldown counter=0, FSM=READY, key history=0, VS sync chain=0.
- VS passes through a 2-flop synchroniser plus an edge register. frame_tick=1 for exactly one Clk on each synchronised rising edge, 3 Clk after the VS rise.
- fire_key is sampled only when frame_tick=1. press = sampled 1 while the previous sample was 0. No autofire; holding the key launches once.
- FSM states:
  - READY: on frame_tick with press, shootingEnable=1 and a free slot, launch and go to COOLDOWN with the counter loaded to COOLDOWN_FRAMES-1. If any condition fails, the press is dropped, not queued.
  - COOLDOWN: counter decrements on each frame_tick; at 0 on a frame_tick, go to READY. A press during COOLDOWN is ignored, and its history still updates.
  - shootingEnable=0 forces READY→READY; it does not abort an active COOLDOWN.
- Launch timing: fire is asserted in the Clk after the qualifying frame_tick, with spawnX/spawnY/spawnDir registered from inputs sampled on the frame_tick cycle. Latency is 1 Clk from frame_tick.
- Slot selection: the lowest-index slot with slot_busy=0, computed from registered slot_busy.
- slot_busy[i] sets in the same cycle fire[i] is asserted and clears in the cycle after bullet_done[i]=1.
- If bullet_done[i] and the allocation decision fall in the same cycle, slot i still counts as busy for that decision. It becomes eligible from the next frame.
- bullet_done on a non-busy slot is ignored.
- All slots busy: press dropped, FSM stays READY, no fire.
- Spawn arithmetic uses 11-bit intermediates.
  - direction=1: spawnX = min(PlayerX+PlayerWidth, SCREEN_W-1).
  - direction=0: spawnX = max(PlayerX-BULLET_W, 0).
  - spawnY = min(PlayerY + (PlayerHeight>>2), SCREEN_H-1).
- spawnX/spawnY/spawnDir hold their last launch value between launches.
- Reset mid-flight clears all slot_busy. Downstream slots are reset by the same Reset.

Decomposition:
- Shared package game_pkg: SCREEN_W, SCREEN_H, BULLET_W, typedef dispatch_state_t {READY, COOLDOWN}, and a lowest-free-index priority function.
- One natural sub-module, vs_edge_sync: 2-flop synchroniser plus rising-edge pulse. It is reusable by every VS-driven block.

Test Plan:
- Reset during COOLDOWN with slot_busy=6'b000011 -> all outputs 0 immediately, asynchronously; READY after release.
- Player X=100, Y=200, W=32, H=64, direction=1; fire_key rises; one frame_tick -> next Clk fire=6'b000001, spawnX=132, spawnY=216, spawnDir=1, slot_busy=6'b000001.
- direction=0, X=2 -> spawnX=0 (clamp). X=630, W=32, direction=1 -> spawnX=639.
- COOLDOWN_FRAMES=8: press at frame 0 and again at frame 4 -> only one fire. Release, then press at frame 8 -> fire=6'b000010.
- Fill all 6 slots, press again -> no fire, FSM READY. Pulse bullet_done[3] -> slot_busy[3] clears next Clk; next press -> fire=6'b001000.
- Hold fire_key for 20 frames -> exactly one fire. shootingEnable=0 at press -> no fire, no cooldown entered.
